// File: rtl/matrix_key_scanner.sv
// Column-scanning key matrix decoder with per-frame priority encode, frame-count
// debounce and a single-entry press/release event buffer with overrun flag.
module matrix_key_scanner #(
  parameter int unsigned ROWS     = 4,
  parameter int unsigned COLS     = 4,
  parameter int unsigned SCAN_DIV = 8,
  parameter int unsigned DEBOUNCE = 3,
  localparam int unsigned CW      = $clog2(ROWS * COLS + 1)
) (
  input  logic            Clock,
  input  logic            Reset_N,
  input  logic [ROWS-1:0] Keyb_Row_I,
  output logic [COLS-1:0] Keyb_Col_O,
  output logic [CW-1:0]   Keyb_Value,
  output logic            Evt_Valid,
  output logic [CW-1:0]   Evt_Code,
  output logic            Evt_Press,
  input  logic            Evt_Ready,
  output logic            Evt_Overrun,
  input  logic            Ovr_Clr
);

  localparam int unsigned DivW = $clog2(SCAN_DIV);
  localparam int unsigned ColW = (COLS > 1) ? $clog2(COLS) : 1;
  localparam int unsigned RowW = (ROWS > 1) ? $clog2(ROWS) : 1;
  localparam int unsigned CntW = $clog2(DEBOUNCE + 1);

  typedef enum logic [1:0] {StIdle, StConfirm, StHeld} state_e;

  logic [DivW-1:0] div_q, div_d;
  logic [ColW-1:0] col_q, col_d;
  logic [CW-1:0]   frame_q, frame_d;
  logic [CW-1:0]   cand_q, cand_d;
  logic [CntW-1:0] count_q, count_d;
  logic [CW-1:0]   value_q, value_d;
  state_e          state_q, state_d;
  logic            valid_q, valid_d;
  logic [CW-1:0]   code_q, code_d;
  logic            press_q, press_d;
  logic            ovr_q, ovr_d;

  logic            sample, frame_end, row_hit;
  logic [RowW-1:0] row_idx;
  logic [CW-1:0]   col_code, raw_now;
  logic            new_evt, new_press;
  logic [CW-1:0]   new_code;

  assign sample    = (div_q == DivW'(SCAN_DIV - 1));
  assign frame_end = sample && (col_q == ColW'(COLS - 1));

  // Lowest asserted row wins within a column.
  always_comb begin
    row_hit = 1'b0;
    row_idx = '0;
    for (int r = ROWS - 1; r >= 0; r--) begin
      if (Keyb_Row_I[r]) begin
        row_hit = 1'b1;
        row_idx = RowW'(r);
      end
    end
  end

  assign col_code = row_hit ? CW'(int'(col_q) * ROWS + int'(row_idx) + 1) : '0;
  // Column 0 starts a fresh frame; later columns only fill in if nothing was seen yet.
  assign raw_now  = ((col_q != '0) && (frame_q != '0)) ? frame_q : col_code;

  always_comb begin
    div_d   = div_q + 1'b1;
    col_d   = col_q;
    frame_d = frame_q;
    if (sample) begin
      div_d   = '0;
      frame_d = raw_now;
      col_d   = (col_q == ColW'(COLS - 1)) ? '0 : col_q + 1'b1;
    end
  end

  always_comb begin
    state_d   = state_q;
    cand_d    = cand_q;
    count_d   = count_q;
    value_d   = value_q;
    new_evt   = 1'b0;
    new_press = 1'b0;
    new_code  = '0;
    if (state_q == StConfirm && count_q == CntW'(DEBOUNCE)) begin
      value_d   = cand_q;
      new_evt   = 1'b1;
      new_press = (cand_q != '0);
      new_code  = new_press ? cand_q : value_q;
      state_d   = (cand_q == '0) ? StIdle : StHeld;
    end else if (frame_end) begin
      if (raw_now == cand_q) begin
        if (count_q != CntW'(DEBOUNCE)) count_d = count_q + 1'b1;
      end else begin
        cand_d  = raw_now;
        count_d = CntW'(1);
        if (raw_now != value_q) state_d = StConfirm;
        else if (value_q == '0) state_d = StIdle;
        else                    state_d = StHeld;
      end
    end
  end

  always_comb begin
    valid_d = valid_q;
    code_d  = code_q;
    press_d = press_q;
    ovr_d   = ovr_q;
    if (new_evt) begin
      valid_d = 1'b1;
      code_d  = new_code;
      press_d = new_press;
    end else if (valid_q && Evt_Ready) begin
      valid_d = 1'b0;
    end
    // Set beats clear; an acceptance on the same clock is not an overrun.
    if (new_evt && valid_q && !Evt_Ready) ovr_d = 1'b1;
    else if (Ovr_Clr)                     ovr_d = 1'b0;
  end

  always_ff @(posedge Clock or negedge Reset_N) begin
    if (!Reset_N) begin
      div_q   <= '0;
      col_q   <= '0;
      frame_q <= '0;
      cand_q  <= '0;
      count_q <= '0;
      value_q <= '0;
      state_q <= StIdle;
      valid_q <= 1'b0;
      code_q  <= '0;
      press_q <= 1'b0;
      ovr_q   <= 1'b0;
    end else begin
      div_q   <= div_d;
      col_q   <= col_d;
      frame_q <= frame_d;
      cand_q  <= cand_d;
      count_q <= count_d;
      value_q <= value_d;
      state_q <= state_d;
      valid_q <= valid_d;
      code_q  <= code_d;
      press_q <= press_d;
      ovr_q   <= ovr_d;
    end
  end

  assign Keyb_Col_O  = COLS'(1) << col_q;
  assign Keyb_Value  = value_q;
  assign Evt_Valid   = valid_q;
  assign Evt_Code    = code_q;
  assign Evt_Press   = press_q;
  assign Evt_Overrun = ovr_q;

endmodule

// File: tb/tb_matrix_key_scanner.sv
// Bench for matrix_key_scanner at default parameters: key-matrix model, event scoreboard
// popped on handshake acceptance, plus direct checks of debounce, priority and overrun.
module tb_matrix_key_scanner;

  logic       Clock;
  logic       Reset_N;
  logic [3:0] row_in;
  logic [3:0] Keyb_Col_O;
  logic [4:0] Keyb_Value;
  logic       Evt_Valid;
  logic [4:0] Evt_Code;
  logic       Evt_Press;
  logic       Evt_Ready;
  logic       Evt_Overrun;
  logic       Ovr_Clr;

  logic [15:0] keys;  // bit col*4+row
  logic        glitch;
  int          cyc;
  int          n_chk;
  int          n_fail;
  logic [5:0]  exp_q[$];  // {press, code}

  matrix_key_scanner dut (
    .Clock      (Clock),
    .Reset_N    (Reset_N),
    .Keyb_Row_I (row_in),
    .Keyb_Col_O (Keyb_Col_O),
    .Keyb_Value (Keyb_Value),
    .Evt_Valid  (Evt_Valid),
    .Evt_Code   (Evt_Code),
    .Evt_Press  (Evt_Press),
    .Evt_Ready  (Evt_Ready),
    .Evt_Overrun(Evt_Overrun),
    .Ovr_Clr    (Ovr_Clr)
  );

  initial Clock = 1'b0;
  always #5 Clock = ~Clock;

  always @(posedge Clock or negedge Reset_N) begin
    if (!Reset_N) cyc <= 0;
    else          cyc <= cyc + 1;
  end

  // Glitch mode drives rows only during settling clocks, never on the sample clock.
  always_comb begin
    row_in = '0;
    if (glitch) begin
      row_in = (cyc % 8 != 7) ? 4'hF : 4'h0;
    end else begin
      for (int c = 0; c < 4; c++)
        for (int r = 0; r < 4; r++)
          if (Keyb_Col_O[c] && keys[c*4+r]) row_in[r] = 1'b1;
    end
  end

  task automatic check_eq(input string tag, input int unsigned obs, input int unsigned exp);
    n_chk++;
    if (obs != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  always @(negedge Clock) begin
    if (Reset_N && Evt_Valid && Evt_Ready) begin
      if (exp_q.size() == 0) check_eq("evt_unexpected", {Evt_Press, Evt_Code}, 0);
      else                   check_eq("evt", {Evt_Press, Evt_Code}, exp_q.pop_front());
    end
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge Clock);
      #1;
    end
  endtask

  task automatic frame_ends(input int n);
    for (int i = 0; i < n; i++) begin
      do begin
        @(posedge Clock);
        #1;
      end while (cyc % 32 != 0);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    n_chk = 0; n_fail = 0;
    Reset_N = 1'b0; Evt_Ready = 1'b0; Ovr_Clr = 1'b0; keys = '0; glitch = 1'b0;
    #17;
    check_eq("rst_col", Keyb_Col_O, 4'b0001);
    check_eq("rst_val", Keyb_Value, 0);
    check_eq("rst_valid", Evt_Valid, 0);
    check_eq("rst_ovr", Evt_Overrun, 0);
    @(negedge Clock);
    Reset_N = 1'b1;

    // Key 7 (col 1, row 2), consumer stalled.
    keys = 16'h0040;
    exp_q.push_back({1'b1, 5'd7});
    frame_ends(3);
    check_eq("press_pre", Keyb_Value, 0);
    tick(1);
    check_eq("press_val", Keyb_Value, 7);
    check_eq("press_valid", Evt_Valid, 1);
    check_eq("press_code", Evt_Code, 7);
    check_eq("press_flag", Evt_Press, 1);
    frame_ends(1);
    check_eq("hold_valid", Evt_Valid, 1);
    check_eq("hold_code", Evt_Code, 7);
    Evt_Ready = 1'b1;
    tick(1);
    check_eq("acc_valid", Evt_Valid, 0);

    // Release key 7.
    frame_ends(1);
    keys = '0;
    exp_q.push_back({1'b0, 5'd7});
    frame_ends(3);
    tick(1);
    check_eq("rel_val", Keyb_Value, 0);
    tick(1);
    check_eq("rel_valid", Evt_Valid, 0);

    // Bounce: two frames only.
    frame_ends(1);
    keys = 16'h0040;
    frame_ends(2);
    keys = '0;
    frame_ends(3);
    tick(1);
    check_eq("bounce_val", Keyb_Value, 0);
    check_eq("bounce_valid", Evt_Valid, 0);

    // Rows asserted only while settling must never be seen.
    frame_ends(1);
    glitch = 1'b1;
    frame_ends(4);
    tick(1);
    check_eq("settle_val", Keyb_Value, 0);
    glitch = 1'b0;

    // Priority: key 4 (col 0 row 3) beats key 9 (col 2 row 0).
    frame_ends(1);
    keys = 16'h0108;
    exp_q.push_back({1'b1, 5'd4});
    frame_ends(3);
    tick(1);
    check_eq("prio_val", Keyb_Value, 4);
    frame_ends(1);
    keys = '0;
    exp_q.push_back({1'b0, 5'd4});
    frame_ends(3);
    tick(1);
    check_eq("prio_rel", Keyb_Value, 0);

    // Direct change 7 -> 9 emits only press 9.
    frame_ends(1);
    keys = 16'h0040;
    exp_q.push_back({1'b1, 5'd7});
    frame_ends(3);
    tick(1);
    frame_ends(1);
    keys = 16'h0100;
    exp_q.push_back({1'b1, 5'd9});
    frame_ends(3);
    tick(1);
    check_eq("ab_val", Keyb_Value, 9);
    frame_ends(1);
    keys = '0;
    exp_q.push_back({1'b0, 5'd9});
    frame_ends(3);
    tick(2);
    Evt_Ready = 1'b0;

    // Overrun: press 7 is overwritten by release 7; clear on the set clock loses.
    frame_ends(1);
    keys = 16'h0040;
    frame_ends(3);
    tick(1);
    check_eq("ovr_pend", Evt_Valid, 1);
    check_eq("ovr_none", Evt_Overrun, 0);
    frame_ends(1);
    keys = '0;
    exp_q.push_back({1'b0, 5'd7});
    frame_ends(3);
    Ovr_Clr = 1'b1;
    tick(1);
    check_eq("ovr_set", Evt_Overrun, 1);
    check_eq("ovr_code", Evt_Code, 7);
    check_eq("ovr_press", Evt_Press, 0);
    tick(1);
    check_eq("ovr_clr", Evt_Overrun, 0);
    Ovr_Clr = 1'b0;
    Evt_Ready = 1'b1;
    tick(1);
    check_eq("ovr_drain", Evt_Valid, 0);
    Evt_Ready = 1'b0;

    // Acceptance on the same clock as a new event.
    frame_ends(1);
    keys = 16'h0040;
    exp_q.push_back({1'b1, 5'd7});
    frame_ends(3);
    tick(1);
    frame_ends(1);
    keys = '0;
    exp_q.push_back({1'b0, 5'd7});
    frame_ends(3);
    Evt_Ready = 1'b1;
    tick(1);
    check_eq("same_valid", Evt_Valid, 1);
    check_eq("same_ovr", Evt_Overrun, 0);
    check_eq("same_press", Evt_Press, 0);
    tick(1);
    check_eq("same_done", Evt_Valid, 0);
    Evt_Ready = 1'b0;

    // Asynchronous reset mid-scan with an event pending.
    frame_ends(1);
    keys = 16'h0040;
    frame_ends(3);
    tick(1);
    check_eq("mid_pend", Evt_Valid, 1);
    tick(5);
    #3 Reset_N = 1'b0;
    #1;
    check_eq("mid_col", Keyb_Col_O, 4'b0001);
    check_eq("mid_val", Keyb_Value, 0);
    check_eq("mid_valid", Evt_Valid, 0);
    check_eq("mid_ovr", Evt_Overrun, 0);
    @(negedge Clock);
    Reset_N = 1'b1;
    frame_ends(2);
    check_eq("post_valid", Evt_Valid, 0);
    frame_ends(1);
    check_eq("post_val0", Keyb_Value, 0);
    tick(1);
    check_eq("post_val", Keyb_Value, 7);
    exp_q.push_back({1'b1, 5'd7});
    Evt_Ready = 1'b1;
    tick(2);
    check_eq("post_done", Evt_Valid, 0);

    check_eq("sb_empty", exp_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
